// File: rtl/banco_registros_param.sv
// Parametrised register bank with two read ports, decoder and ALU write ports,
// and a saturating hardware return-address stack with a sticky error flag.
module banco_registros_param #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int ACC_IDX   = 0,
  parameter int PC_W      = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Wr_En,
  input  logic [$clog2(NUM_REGS)-1:0]    i_Wr_Addr,
  input  logic [DATA_W-1:0]              i_Wr_Data,
  input  logic                           i_Alu_Wr_En,
  input  logic [DATA_W-1:0]              i_Resultado_ALU,
  input  logic [$clog2(NUM_REGS)-1:0]    i_RdA_Addr,
  input  logic [$clog2(NUM_REGS)-1:0]    i_RdB_Addr,
  output logic [DATA_W-1:0]              o_RdA_Data,
  output logic [DATA_W-1:0]              o_RdB_Data,
  input  logic                           i_Call,
  input  logic                           i_Ret,
  input  logic [PC_W-1:0]                i_Direccion_PC,
  output logic [PC_W-1:0]                o_Direccion_Retorno,
  output logic [$clog2(STK_DEPTH):0]     o_Pila_Nivel,
  output logic                           o_Pila_Llena,
  output logic                           o_Pila_Vacia,
  output logic                           o_Pila_Error,
  input  logic                           i_Error_Clr
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int SW = $clog2(STK_DEPTH) + 1;

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [PC_W-1:0]   stk_r  [STK_DEPTH];
  logic [SW-1:0]     sp_r;
  logic              err_r;

  logic [SW-1:0]     top_ptr_s;
  logic [SW-2:0]     top_idx_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              repl_s;
  logic              err_set_s;

  assign full_s    = (sp_r == SW'(STK_DEPTH));
  assign empty_s   = (sp_r == {SW{1'b0}});
  assign top_ptr_s = sp_r - {{(SW-1){1'b0}}, 1'b1};
  assign top_idx_s = top_ptr_s[SW-2:0];

  assign o_RdA_Data          = regs_r[i_RdA_Addr];
  assign o_RdB_Data          = regs_r[i_RdB_Addr];
  assign o_Direccion_Retorno = empty_s ? {PC_W{1'b0}} : stk_r[top_idx_s];
  assign o_Pila_Nivel        = sp_r;
  assign o_Pila_Llena        = full_s;
  assign o_Pila_Vacia        = empty_s;
  assign o_Pila_Error        = err_r;

  // Decode the single stack operation allowed this cycle; a call+ret pair is a tail call.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    repl_s    = 1'b0;
    err_set_s = 1'b0;
    case ({i_Call, i_Ret})
      2'b10: begin
        if (full_s) err_set_s = 1'b1;
        else        push_s    = 1'b1;
      end
      2'b01: begin
        if (empty_s) err_set_s = 1'b1;
        else         pop_s     = 1'b1;
      end
      2'b11: begin
        if (empty_s) push_s = 1'b1;
        else         repl_s = 1'b1;
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Register array: the ALU write-back has priority over the decoder on the accumulator.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_Alu_Wr_En && (AW'(i) == AW'(ACC_IDX))) regs_r[i] <= i_Resultado_ALU;
        else if (i_Wr_En && (i_Wr_Addr == AW'(i)))   regs_r[i] <= i_Wr_Data;
        else                                         regs_r[i] <= regs_r[i];
      end
    end
  end

  // Return-address stack storage, saturating pointer and sticky error flag.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int i = 0; i < STK_DEPTH; i++) stk_r[i] <= {PC_W{1'b0}};
      sp_r  <= {SW{1'b0}};
      err_r <= 1'b0;
    end else begin
      if (push_s) begin
        stk_r[sp_r[SW-2:0]] <= i_Direccion_PC;
        sp_r                <= sp_r + {{(SW-1){1'b0}}, 1'b1};
      end else if (repl_s) begin
        stk_r[top_idx_s] <= i_Direccion_PC;
      end else if (pop_s) begin
        sp_r <= top_ptr_s;
      end else begin
        sp_r <= sp_r;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (err_set_s)        err_r <= 1'b1;
      else if (i_Error_Clr) err_r <= 1'b0;
      else                  err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed self-checking bench for banco_registros_param with default parameters.
module tb_banco_registros_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       alu_en;
  logic [7:0] alu_data;
  logic [2:0] rda_addr;
  logic [2:0] rdb_addr;
  logic [7:0] rda_data;
  logic [7:0] rdb_data;
  logic       call;
  logic       ret;
  logic [7:0] pc;
  logic [7:0] dir_ret;
  logic [2:0] nivel;
  logic       llena;
  logic       vacia;
  logic       perr;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  banco_registros_param dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
    .i_Alu_Wr_En(alu_en), .i_Resultado_ALU(alu_data),
    .i_RdA_Addr(rda_addr), .i_RdB_Addr(rdb_addr),
    .o_RdA_Data(rda_data), .o_RdB_Data(rdb_data),
    .i_Call(call), .i_Ret(ret), .i_Direccion_PC(pc),
    .o_Direccion_Retorno(dir_ret), .o_Pila_Nivel(nivel),
    .o_Pila_Llena(llena), .o_Pila_Vacia(vacia), .o_Pila_Error(perr),
    .i_Error_Clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; alu_en = 1'b0; call = 1'b0; ret = 1'b0; err_clr = 1'b0;
  endtask

  task automatic stack_op(input logic c, input logic r, input logic [7:0] p);
    call = c; ret = r; pc = p;
    step();
    call = 1'b0; ret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; idle();
    wr_addr = 3'd0; wr_data = 8'h00; alu_data = 8'h00;
    rda_addr = 3'd0; rdb_addr = 3'd0; pc = 8'h00;
    step(); step();

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rda_addr = 3'(i); rdb_addr = 3'(7 - i); #1;
      check("rst_rda", {24'd0, rda_data}, 32'h0);
      check("rst_rdb", {24'd0, rdb_data}, 32'h0);
    end
    check("rst_vacia", {31'd0, vacia}, 32'd1);
    check("rst_llena", {31'd0, llena}, 32'd0);
    check("rst_nivel", {29'd0, nivel}, 32'd0);
    check("rst_top",   {24'd0, dir_ret}, 32'h0);
    check("rst_err",   {31'd0, perr}, 32'd0);

    @(negedge clk); rst = 1'b1;
    step();

    // Write R3, old value visible until the edge
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rda_addr = 3'd3; #1;
    check("r3_old", {24'd0, rda_data}, 32'h00);
    step();
    check("r3_new", {24'd0, rda_data}, 32'hA5);
    wr_addr = 3'd5; wr_data = 8'h3C;
    step(); idle();
    rda_addr = 3'd3; rdb_addr = 3'd5; #1;
    check("rd_a3", {24'd0, rda_data}, 32'hA5);
    check("rd_b5", {24'd0, rdb_data}, 32'h3C);

    // Conflict on accumulator: ALU wins
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h11; alu_en = 1'b1; alu_data = 8'h77;
    step();
    rda_addr = 3'd0; #1;
    check("acc_conflict", {24'd0, rda_data}, 32'h77);
    wr_addr = 3'd2; wr_data = 8'h22; alu_data = 8'h99;
    step(); idle();
    rda_addr = 3'd0; rdb_addr = 3'd2; #1;
    check("acc_alu", {24'd0, rda_data}, 32'h99);
    check("r2_dec",  {24'd0, rdb_data}, 32'h22);
    rdb_addr = 3'd3; #1;
    check("r3_kept", {24'd0, rdb_data}, 32'hA5);

    // Fill stack
    stack_op(1'b1, 1'b0, 8'h10);
    check("push1_top", {24'd0, dir_ret}, 32'h10);
    stack_op(1'b1, 1'b0, 8'h20);
    stack_op(1'b1, 1'b0, 8'h30);
    stack_op(1'b1, 1'b0, 8'h40);
    check("full_llena", {31'd0, llena}, 32'd1);
    check("full_nivel", {29'd0, nivel}, 32'd4);
    check("full_top",   {24'd0, dir_ret}, 32'h40);
    check("full_err",   {31'd0, perr}, 32'd0);
    stack_op(1'b1, 1'b0, 8'h50);
    check("ovf_top",   {24'd0, dir_ret}, 32'h40);
    check("ovf_nivel", {29'd0, nivel}, 32'd4);
    check("ovf_err",   {31'd0, perr}, 32'd1);
    stack_op(1'b0, 1'b0, 8'h00);
    check("err_sticky", {31'd0, perr}, 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr", {31'd0, perr}, 32'd0);

    // Drain to level 2, then pop with same-cycle return address
    stack_op(1'b0, 1'b1, 8'h00);
    stack_op(1'b0, 1'b1, 8'h00);
    check("lvl2", {29'd0, nivel}, 32'd2);
    ret = 1'b1; #1;
    check("pop_top20", {24'd0, dir_ret}, 32'h20);
    step();
    check("pop_top10", {24'd0, dir_ret}, 32'h10);
    step(); ret = 1'b0;
    check("pop_empty_top", {24'd0, dir_ret}, 32'h0);
    check("pop_empty_vacia", {31'd0, vacia}, 32'd1);
    check("pop_empty_err", {31'd0, perr}, 32'd0);
    stack_op(1'b0, 1'b1, 8'h00);
    check("udf_err",   {31'd0, perr}, 32'd1);
    check("udf_nivel", {29'd0, nivel}, 32'd0);
    check("udf_top",   {24'd0, dir_ret}, 32'h0);

    // Clear and a new error on the same edge: error wins
    err_clr = 1'b1; stack_op(1'b0, 1'b1, 8'h00); err_clr = 1'b0;
    check("clr_vs_err", {31'd0, perr}, 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("clr2", {31'd0, perr}, 32'd0);

    // Tail call on empty acts as push without error
    stack_op(1'b1, 1'b1, 8'h10);
    check("tail_empty_nivel", {29'd0, nivel}, 32'd1);
    check("tail_empty_top",   {24'd0, dir_ret}, 32'h10);
    check("tail_empty_err",   {31'd0, perr}, 32'd0);
    stack_op(1'b1, 1'b0, 8'h20);
    stack_op(1'b1, 1'b1, 8'h55);
    check("tail_nivel", {29'd0, nivel}, 32'd2);
    check("tail_top",   {24'd0, dir_ret}, 32'h55);
    stack_op(1'b0, 1'b1, 8'h00);
    check("tail_below", {24'd0, dir_ret}, 32'h10);
    stack_op(1'b1, 1'b0, 8'h55);
    stack_op(1'b0, 1'b1, 8'h00);
    stack_op(1'b0, 1'b1, 8'h00);
    stack_op(1'b0, 1'b1, 8'h00);
    check("err_before_rst", {31'd0, perr}, 32'd1);
    stack_op(1'b1, 1'b0, 8'h66);

    // Asynchronous reset mid-cycle with operations pending
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hEE; call = 1'b1; pc = 8'h77;
    rda_addr = 3'd0; rdb_addr = 3'd3;
    #2 rst = 1'b0; #1;
    check("arst_rda",   {24'd0, rda_data}, 32'h0);
    check("arst_rdb",   {24'd0, rdb_data}, 32'h0);
    check("arst_nivel", {29'd0, nivel}, 32'd0);
    check("arst_vacia", {31'd0, vacia}, 32'd1);
    check("arst_top",   {24'd0, dir_ret}, 32'h0);
    check("arst_err",   {31'd0, perr}, 32'd0);
    step();
    check("arst_hold_rdb", {24'd0, rdb_data}, 32'h0);
    check("arst_hold_nivel", {29'd0, nivel}, 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
- Parametrised successor to the fixed 8x8 register bank of the UAZ microcontroller datapath.
- Provides N general registers of configurable width, with two independent combinational read ports, one decoder write port, and a dedicated ALU write-back port to the accumulator register.
- Replaces the single link register with a hardware return-address stack of configurable depth.
- Sits between the instruction decoder, the ALU and the PC/jump unit.

Parameters:
DATA_W, 8, register and data width in bits
NUM_REGS, 8, number of general registers (power of 2, >= 2)
ACC_IDX, 0, index of the accumulator written by the ALU port
PC_W, 8, program-counter / return-address width
STK_DEPTH, 4, return-address stack entries (power of 2, >= 2)

Ports:
i_Clk  in  1  system clock, rising edge
i_Rst  in  1  asynchronous reset, active-low
i_Wr_En  in  1  decoder write enable
i_Wr_Addr  in  log2(NUM_REGS)  decoder write index
i_Wr_Data  in  DATA_W  decoder write data
i_Alu_Wr_En  in  1  ALU write-back enable (targets ACC_IDX)
i_Resultado_ALU  in  DATA_W  ALU result
i_RdA_Addr  in  log2(NUM_REGS)  read port A index
i_RdB_Addr  in  log2(NUM_REGS)  read port B index
o_RdA_Data  out  DATA_W  read port A data
o_RdB_Data  out  DATA_W  read port B data
i_Call  in  1  push i_Direccion_PC onto return stack
i_Ret  in  1  pop return stack
i_Direccion_PC  in  PC_W  return address to push
o_Direccion_Retorno  out  PC_W  top of stack (0 when empty)
o_Pila_Nivel  out  log2(STK_DEPTH)+1  current stack occupancy
o_Pila_Llena  out  1  occupancy == STK_DEPTH
o_Pila_Vacia  out  1  occupancy == 0
o_Pila_Error  out  1  sticky overflow/underflow flag
i_Error_Clr  in  1  synchronous clear of o_Pila_Error

Behaviour:
- Reset (i_Rst=0, asynchronous):
  - all registers and stack entries = 0; stack pointer = 0; o_Pila_Error = 0.
  - Outputs: read data 0, o_Direccion_Retorno 0, o_Pila_Nivel 0, o_Pila_Vacia 1, o_Pila_Llena 0.
- Deassertion of reset is sampled on the next rising edge; no operation in the first edge with i_Rst=0.
- Register writes: on rising edge, 1-cycle latency. Decoder port writes i_Wr_Data to i_Wr_Addr when i_Wr_En; ALU port writes i_Resultado_ALU to ACC_IDX when i_Alu_Wr_En.
- Write conflict (both enabled, i_Wr_Addr == ACC_IDX): ALU wins; decoder data discarded. Both enabled to different indices: both written.
- Reads: combinational from the stored array; no write-through bypass. A read of the address being written returns the old value until the edge.
- Stack, one operation per edge:
  - Push only (i_Call=1, i_Ret=0):
    - not full: entry[sp] <= i_Direccion_PC, sp <= sp+1.
    - full: no change, o_Pila_Error <= 1.
  - Pop only (i_Call=0, i_Ret=1):
    - not empty: sp <= sp-1.
    - empty: no change, o_Pila_Error <= 1.
  - Both (tail call):
    - not empty: top entry <= i_Direccion_PC, sp unchanged.
    - empty: acts as push, no error.
- o_Direccion_Retorno = entry[sp-1] when sp>0, else 0. The value is combinational, so the jump unit reads it in the same cycle i_Ret is asserted; the pop takes effect at the edge.
- o_Pila_Nivel = sp. Flags are derived combinationally from sp.
- o_Pila_Error is sticky. i_Error_Clr clears it at the edge. If a clear and a new error occur in the same edge, the error wins (flag stays 1).
- Stack entries never wrap: sp is saturating in [0, STK_DEPTH].
- Reset mid-operation: the asynchronous reset overrides any pending write or stack operation immediately.

Test Plan:
- Reset then read all regs -> o_RdA_Data = o_RdB_Data = 0 for every index; o_Pila_Vacia=1, o_Pila_Nivel=0.
- Write R3=0xA5 and R5=0x3C on consecutive cycles; read A=3, B=5 -> 0xA5 / 0x3C; same-cycle read of R3 during its write returns the old value 0x00.
- i_Wr_En with addr 0, data 0x11, together with i_Alu_Wr_En, data 0x77 -> R0=0x77. Next cycle write R2=0x22 with ALU data 0x99 -> R2=0x22, R0=0x99.
- Push PC 0x10,0x20,0x30,0x40 (depth 4) -> o_Pila_Llena=1, top=0x40. Fifth push of 0x50 -> top stays 0x40, o_Pila_Error=1. Then i_Error_Clr -> error 0.
- Pops from level 2 (0x10,0x20): o_Direccion_Retorno = 0x20 then 0x10. Third pop -> o_Direccion_Retorno=0, o_Pila_Error=1, o_Pila_Nivel=0.
- Stack holds 0x10,0x20; i_Call+i_Ret with PC=0x55 -> level 2, top 0x55. Assert i_Rst low mid-cycle -> all outputs to reset values before the next edge.
